// File: rtl/hnext_sched.sv
// hnext_sched: issues (h,p) tiles to the FP16 hnext adder array over a multi-timestep scan.
// Latency: read strobe same cycle as fire, add_valid_o +1, write strobe at fire+1+A_LAT.
// Backpressure: in_ready_o drops while the current tile's previous result is unwritten. Optional HNEXT_SCHED_PERF_EN adds stall/starve counters.
module hnext_sched #(
    parameter int NUM_TILES = 16,
    parameter int TILE_W    = 4,
    parameter int LEN_W     = 16,
    parameter int A_LAT     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  seq_len_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              st_rd_en_o,
    output logic [TILE_W-1:0] st_rd_addr_o,
    output logic              add_valid_o,
    input  logic              add_valid_i,
    output logic              st_wr_en_o,
    output logic [TILE_W-1:0] st_wr_addr_o,
    output logic              busy_o,
    output logic              step_done_o,
    output logic              done_o,
`ifdef HNEXT_SCHED_PERF_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       starve_cnt_o,
`endif
    output logic              err_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

    state_t                       state_q, state_d;
    logic [LEN_W-1:0]             len_q, step_cnt_q, wr_step_q;
    logic [TILE_W-1:0]            tile_cnt_q, wr_cnt_q, add_tile_q;
    logic [NUM_TILES-1:0]         pending_q, pend_set, pend_clr;
    logic                         add_vld_q, zero_done_q, err_q;
    logic [A_LAT-1:0]             dly_vld_q;
    logic [A_LAT-1:0][TILE_W-1:0] dly_tile_q;

    logic              start_ok, fire, last_tile, last_step;
    logic              wr_en, wr_wrap, final_wr;
    logic [TILE_W-1:0] wr_addr;

    assign start_ok  = (state_q == S_IDLE) && start_i;
    assign in_ready_o = (state_q == S_RUN) && !pending_q[tile_cnt_q];
    assign fire      = in_valid_i && in_ready_o;
    assign last_tile = (tile_cnt_q == LAST_TILE);
    assign last_step = (step_cnt_q == len_q - LEN_W'(1));

    assign wr_en    = dly_vld_q[A_LAT-1];
    assign wr_addr  = dly_tile_q[A_LAT-1];
    assign wr_wrap  = wr_en && (wr_cnt_q == LAST_TILE);
    assign final_wr = wr_wrap && (state_q == S_DRAIN) && (wr_step_q == len_q - LEN_W'(1));

    assign pend_set = fire  ? (NUM_TILES'(1) << tile_cnt_q) : '0;
    assign pend_clr = wr_en ? (NUM_TILES'(1) << wr_addr)    : '0;

    assign st_rd_en_o   = fire;
    assign st_rd_addr_o = fire ? tile_cnt_q : '0;
    assign add_valid_o  = add_vld_q;
    assign st_wr_en_o   = wr_en;
    assign st_wr_addr_o = wr_en ? wr_addr : '0;
    assign busy_o       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign step_done_o  = wr_wrap;
    assign done_o       = final_wr || zero_done_q;
    assign err_o        = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && (seq_len_i != '0)) state_d = S_RUN;
            S_RUN:   if (fire && last_tile && last_step) state_d = S_DRAIN;
            S_DRAIN: if (final_wr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            step_cnt_q  <= '0;
            wr_step_q   <= '0;
            tile_cnt_q  <= '0;
            wr_cnt_q    <= '0;
            add_tile_q  <= '0;
            pending_q   <= '0;
            add_vld_q   <= 1'b0;
            zero_done_q <= 1'b0;
            err_q       <= 1'b0;
            dly_vld_q   <= '0;
            dly_tile_q  <= '0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= start_ok && (seq_len_i == '0);
            add_vld_q   <= fire;
            if (fire) add_tile_q <= tile_cnt_q;
            // The internal delay line, not add_valid_i, is authoritative for writes.
            dly_vld_q   <= {dly_vld_q[A_LAT-2:0], add_vld_q};
            dly_tile_q  <= {dly_tile_q[A_LAT-2:0], add_tile_q};
            pending_q   <= (pending_q | pend_set) & ~pend_clr;
            if (add_valid_i != wr_en) err_q <= 1'b1;
            if (start_ok) begin
                len_q      <= seq_len_i;
                tile_cnt_q <= '0;
                step_cnt_q <= '0;
                wr_cnt_q   <= '0;
                wr_step_q  <= '0;
            end else begin
                if (fire) begin
                    tile_cnt_q <= last_tile ? '0 : tile_cnt_q + TILE_W'(1);
                    if (last_tile) step_cnt_q <= step_cnt_q + LEN_W'(1);
                end
                if (wr_en) begin
                    wr_cnt_q <= wr_wrap ? '0 : wr_cnt_q + TILE_W'(1);
                    if (wr_wrap) wr_step_q <= wr_step_q + LEN_W'(1);
                end
            end
        end
    end

`ifdef HNEXT_SCHED_PERF_EN
    logic [31:0] stall_cnt_q, starve_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else if (state_q == S_RUN) begin
            if (in_valid_i && !in_ready_o && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!in_valid_i && (starve_cnt_q != '1))
                starve_cnt_q <= starve_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign starve_cnt_o = starve_cnt_q;
`endif

endmodule

// File: tb/tb_hnext_sched.sv
// Directed bench for hnext_sched: a 16-tile instance and a 4-tile instance, each with an A_LAT adder model.
module tb_hnext_sched;
    localparam int A_LAT = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, inj;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // 16-tile instance
    logic        start, in_valid, in_ready, rd_en, add_vo, add_vi, wr_en, busy, step_done, done, err;
    logic [15:0] seq_len;
    logic [3:0]  rd_addr, wr_addr;
    // 4-tile instance
    logic        start4, in_valid4, in_ready4, rd_en4, add_vo4, add_vi4, wr_en4, busy4, step_done4, done4, err4;
    logic [15:0] seq_len4;
    logic [1:0]  rd_addr4, wr_addr4;
`ifdef HNEXT_SCHED_PERF_EN
    logic [31:0] stall_cnt, starve_cnt, stall_cnt4, starve_cnt4;
`endif

    hnext_sched #(.NUM_TILES(16), .TILE_W(4), .LEN_W(16), .A_LAT(A_LAT)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .seq_len_i(seq_len),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .st_rd_en_o(rd_en), .st_rd_addr_o(rd_addr),
        .add_valid_o(add_vo), .add_valid_i(add_vi),
        .st_wr_en_o(wr_en), .st_wr_addr_o(wr_addr),
        .busy_o(busy), .step_done_o(step_done), .done_o(done),
`ifdef HNEXT_SCHED_PERF_EN
        .stall_cnt_o(stall_cnt), .starve_cnt_o(starve_cnt),
`endif
        .err_o(err)
    );

    hnext_sched #(.NUM_TILES(4), .TILE_W(2), .LEN_W(16), .A_LAT(A_LAT)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .seq_len_i(seq_len4),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4),
        .st_rd_en_o(rd_en4), .st_rd_addr_o(rd_addr4),
        .add_valid_o(add_vo4), .add_valid_i(add_vi4),
        .st_wr_en_o(wr_en4), .st_wr_addr_o(wr_addr4),
        .busy_o(busy4), .step_done_o(step_done4), .done_o(done4),
`ifdef HNEXT_SCHED_PERF_EN
        .stall_cnt_o(stall_cnt4), .starve_cnt_o(starve_cnt4),
`endif
        .err_o(err4)
    );

    // Adder array models: pure A_LAT-cycle valid pipes, flushed by rst.
    logic [A_LAT-1:0] pipe, pipe4;
    always @(posedge clk) begin
        if (rst) begin
            pipe  <= '0;
            pipe4 <= '0;
        end else begin
            pipe  <= {pipe[A_LAT-2:0], add_vo};
            pipe4 <= {pipe4[A_LAT-2:0], add_vo4};
        end
    end
    assign add_vi  = pipe[A_LAT-1] & ~inj;
    assign add_vi4 = pipe4[A_LAT-1];

    // Event logs
    int rd_cyc[$], rd_a[$], wr_cyc[$], wr_a[$], done_cyc[$], step_cyc[$];
    int rd4_cyc[$], step4_cyc[$], done4_cyc[$];
    int wr4_cnt = 0;
    int hazard4 = 0;
    bit busy_seen = 0;
    bit pend_m [4] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        if (rd_en)     begin rd_cyc.push_back(cyc); rd_a.push_back(int'(rd_addr)); end
        if (wr_en)     begin wr_cyc.push_back(cyc); wr_a.push_back(int'(wr_addr)); end
        if (done)      done_cyc.push_back(cyc);
        if (step_done) step_cyc.push_back(cyc);
        if (busy)      busy_seen = 1;
    end

    always @(negedge clk) begin
        if (rd_en4 && pend_m[rd_addr4]) hazard4++;
        if (wr_en4) begin pend_m[wr_addr4] = 0; wr4_cnt++; end
        if (rd_en4) begin pend_m[rd_addr4] = 1; rd4_cyc.push_back(cyc); end
        if (step_done4) step4_cyc.push_back(cyc);
        if (done4)      done4_cyc.push_back(cyc);
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string tag, input int act, input int exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); rd_a.delete(); wr_cyc.delete(); wr_a.delete();
        done_cyc.delete(); step_cyc.delete();
        busy_seen = 0;
    endtask

    task automatic start16(input int len, output int s);
        start   = 1'b1;
        seq_len = 16'(len);
        s       = cyc;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done16(input int budget);
        for (int i = 0; i < budget && done_cyc.size() == 0; i++) tick();
        repeat (3) tick();
    endtask

    // One stall-free 16-tile step started in cycle s: reads s+1.., writes 12 later.
    task automatic check_clean16(input string p, input int s);
        check({p, "_rd_count"}, rd_cyc.size(), 16);
        check({p, "_wr_count"}, wr_cyc.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_rd_addr%0d", p, i), qget(rd_a, i), i);
            check($sformatf("%s_rd_cyc%0d", p, i), qget(rd_cyc, i), s + 1 + i);
            check($sformatf("%s_wr_addr%0d", p, i), qget(wr_a, i), i);
            check($sformatf("%s_wr_cyc%0d", p, i), qget(wr_cyc, i), s + 13 + i);
        end
        check({p, "_done_count"}, done_cyc.size(), 1);
        check({p, "_done_cyc"}, qget(done_cyc, 0), s + 28);
        check({p, "_step_count"}, step_cyc.size(), 1);
        check({p, "_step_cyc"}, qget(step_cyc, 0), s + 28);
        check({p, "_busy_end"}, int'(busy), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, late;
        rst = 1'b1; inj = 1'b0;
        start = 1'b0; seq_len = '0; in_valid = 1'b0;
        start4 = 1'b0; seq_len4 = '0; in_valid4 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_add_valid", int'(add_vo), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step_done", int'(step_done), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst4_outs", int'({in_ready4, rd_en4, add_vo4, wr_en4, busy4, step_done4, done4, err4}), 0);

        // Single step, no stall
        clear_logs();
        in_valid = 1'b1;
        start16(1, s);
        wait_done16(80);
        in_valid = 1'b0;
        check_clean16("t1", s);
        check("t1_err", int'(err), 0);

        // Scoreboard hazard on 4 tiles, 3 steps
        in_valid4 = 1'b1;
        start4 = 1'b1; seq_len4 = 16'd3; s = cyc;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 120 && done4_cyc.size() == 0; i++) tick();
        repeat (3) tick();
        in_valid4 = 1'b0;
        check("t2_rd_count", rd4_cyc.size(), 12);
        check("t2_rd0_cyc", qget(rd4_cyc, 0), s + 1);
        check("t2_rd3_cyc", qget(rd4_cyc, 3), s + 4);
        check("t2_reissue_gap", qget(rd4_cyc, 4) - qget(rd4_cyc, 0), 13);
        check("t2_rd8_cyc", qget(rd4_cyc, 8), s + 27);
        check("t2_wr_count", wr4_cnt, 12);
        check("t2_step_count", step4_cyc.size(), 3);
        check("t2_step0_cyc", qget(step4_cyc, 0), s + 16);
        check("t2_step1_cyc", qget(step4_cyc, 1), s + 29);
        check("t2_step2_cyc", qget(step4_cyc, 2), s + 42);
        check("t2_done_cyc", qget(done4_cyc, 0), s + 42);
        check("t2_hazard", hazard4, 0);
        check("t2_err", int'(err4), 0);
        check("t2_busy_end", int'(busy4), 0);

        // Upstream bubbles, 2 steps
        clear_logs();
        in_valid = 1'(($urandom_range(0, 1)));
        start16(2, s);
        for (int i = 0; i < 600 && done_cyc.size() == 0; i++) begin
            in_valid = 1'(($urandom_range(0, 1)));
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("t3_wr_count", wr_cyc.size(), 32);
        check("t3_rd_count", rd_cyc.size(), 32);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t3_wr_addr%0d", i), qget(wr_a, i), i % 16);
            check($sformatf("t3_rd_addr%0d", i), qget(rd_a, i), i % 16);
        end
        check("t3_step_count", step_cyc.size(), 2);
        check("t3_done_count", done_cyc.size(), 1);
        check("t3_err", int'(err), 0);

        // Zero length
        clear_logs();
        start16(0, s);
        repeat (5) tick();
        check("t4_done_count", done_cyc.size(), 1);
        check("t4_done_cyc", qget(done_cyc, 0), s + 1);
        check("t4_rd_count", rd_cyc.size(), 0);
        check("t4_wr_count", wr_cyc.size(), 0);
        check("t4_busy_seen", int'(busy_seen), 0);

        // Reset 5 cycles into DRAIN (DRAIN starts s+17), then a clean rerun
        clear_logs();
        in_valid = 1'b1;
        start16(1, s);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy", int'(busy), 0);
        check("t5_wr_en", int'(wr_en), 0);
        check("t5_rd_en", int'(rd_en), 0);
        check("t5_add_valid", int'(add_vo), 0);
        check("t5_in_ready", int'(in_ready), 0);
        check("t5_done", int'(done), 0);
        check("t5_err", int'(err), 0);
        repeat (20) tick();
        late = 0;
        foreach (wr_cyc[i]) if (wr_cyc[i] > s + 21) late++;
        check("t5_late_writes", late, 0);
        check("t5_wr_before_rst", wr_cyc.size(), 9);
        check("t5_done_count", done_cyc.size(), 0);
        clear_logs();
        start16(1, s);
        wait_done16(80);
        check_clean16("t5b", s);

        // Valid mismatch: drop add_valid_i in cycle s+15 (tile 2's write)
        clear_logs();
        start16(1, s);
        repeat (14) tick();
        check("t6_wr_expected", int'(wr_en), 1);
        check("t6_err_before", int'(err), 0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        check("t6_err_rise", int'(err), 1);
        wait_done16(80);
        in_valid = 1'b0;
        check_clean16("t6", s);
        check("t6_err_sticky", int'(err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_err_cleared", int'(err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
